pipeline_controller: RTL and testbench

- Central stall/flush sequencer for a linear chain of NUM_STAGES pipeline registers (e.g. the MPT walk pipeline).
- Merges per-stage stall requests into back-pressure, and runs timed masked flushes.
- Runs a halt/drain handshake so software or an invalidation unit can quiesce the pipe.
- Drives each stage's s_ctrl_stall / s_ctrl_flush.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipe_stall_chain.sv | 20 ++
 rtl/pipeline_controller.sv | 131 +++++++++++++
 tb/tb_pipeline_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default sizes for the pipeline stall/flush controller.
// Imported by pipeline_controller and its sub-modules.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_IDLE,
    PC_FLUSH,
    PC_DRAIN,
    PC_HALTED
  } pipe_ctrl_state_e;

  localparam int unsigned NumStagesDefault   = 4;
  localparam int unsigned FlushCyclesDefault = 1;
  localparam int unsigned CntWidthDefault    = 32;

endpackage

// File: rtl/pipe_stall_chain.sv
// Combinational suffix-OR back-pressure network: a stall at stage i freezes every
// stage upstream of it (lower index), with zero latency.
module pipe_stall_chain #(
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic [NUM_STAGES-1:0] stall_req_i,
  output logic [NUM_STAGES-1:0] chain_o
);

  always_comb begin
    logic acc;
    acc     = 1'b0;
    chain_o = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      acc        = acc | stall_req_i[i];
      chain_o[i] = acc;
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for a linear pipeline: back-pressure, timed masked flushes
// and a halt/drain handshake. Optional stall counter under PIPE_CTRL_PERF_EN.
module pipeline_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = NumStagesDefault,
  parameter int unsigned FLUSH_CYCLES = FlushCyclesDefault,
  parameter int unsigned CNT_WIDTH    = CntWidthDefault
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_STAGES-1:0] stall_req_i,
  input  logic [NUM_STAGES-1:0] stage_valid_i,
  input  logic                  flush_req_i,
  input  logic [NUM_STAGES-1:0] flush_mask_i,
  output logic                  flush_ack_o,
  input  logic                  halt_req_i,
  output logic                  halt_ack_o,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  busy_o,
  input  logic                  perf_clear_i,
  output logic [CNT_WIDTH-1:0]  stall_cycles_o
);

  localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FcW-1:0] FcLoad = FcW'(FLUSH_CYCLES - 1);

  logic [NUM_STAGES-1:0] chain;

  pipe_stall_chain #(
    .NUM_STAGES(NUM_STAGES)
  ) u_stall_chain (
    .stall_req_i(stall_req_i),
    .chain_o    (chain)
  );

  pipe_ctrl_state_e      state_q, state_d;
  logic [FcW-1:0]        fcnt_q, fcnt_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic                  start_flush;
  logic                  empty;

  assign empty = ~|stage_valid_i;

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    mask_d      = mask_q;
    start_flush = 1'b0;
    unique case (state_q)
      PC_IDLE: begin
        if (flush_req_i)     start_flush = 1'b1;
        else if (halt_req_i) state_d = PC_DRAIN;
      end
      PC_FLUSH: begin
        if (fcnt_q == '0) state_d = halt_req_i ? PC_DRAIN : PC_IDLE;
        else              fcnt_d  = fcnt_q - FcW'(1);
      end
      PC_DRAIN: begin
        if (flush_req_i)      start_flush = 1'b1;
        else if (!halt_req_i) state_d = PC_IDLE;
        else if (empty)       state_d = PC_HALTED;
      end
      PC_HALTED: begin
        if (flush_req_i)      start_flush = 1'b1;
        else if (!halt_req_i) state_d = PC_IDLE;
      end
      default: state_d = PC_IDLE;
    endcase
    if (start_flush) begin
      state_d = PC_FLUSH;
      fcnt_d  = FcLoad;
      mask_d  = flush_mask_i;
    end
  end

  // Outputs are registered from the next-state decode, so they track state_q exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= PC_IDLE;
      fcnt_q      <= '0;
      mask_q      <= '0;
      flush_o     <= '0;
      flush_ack_o <= 1'b0;
      halt_ack_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      mask_q      <= mask_d;
      flush_o     <= (state_d == PC_FLUSH) ? mask_d : '0;
      flush_ack_o <= (state_d == PC_FLUSH) && (fcnt_d == '0);
      halt_ack_o  <= (state_d == PC_HALTED);
      busy_o      <= (state_d != PC_IDLE);
    end
  end

  always_comb begin
    stall_o = '1;
    case (state_q)
      PC_IDLE:  stall_o = chain;
      PC_DRAIN: begin
        stall_o    = chain;
        stall_o[0] = 1'b1;
      end
      default:  stall_o = '1;
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (perf_clear_i) begin
      perf_q <= '0;
    end else if (stall_o[0] && (perf_q != '1)) begin
      perf_q <= perf_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles_o = perf_q;
`else
  logic unused_perf_clear;
  assign unused_perf_clear = perf_clear_i;
  assign stall_cycles_o    = '0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller (NUM_STAGES=4, FLUSH_CYCLES=2, CNT_WIDTH=4).
// Expected per-cycle outputs go through a scoreboard queue; stall counter is modelled.
module tb_pipeline_controller;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic       clk_i;
  logic       rst_ni;
  logic [3:0] stall_req_i;
  logic [3:0] stage_valid_i;
  logic       flush_req_i;
  logic [3:0] flush_mask_i;
  logic       flush_ack_o;
  logic       halt_req_i;
  logic       halt_ack_o;
  logic [3:0] stall_o;
  logic [3:0] flush_o;
  logic       busy_o;
  logic       perf_clear_i;
  logic [3:0] stall_cycles_o;

  pipeline_controller #(
    .NUM_STAGES  (4),
    .FLUSH_CYCLES(2),
    .CNT_WIDTH   (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .stall_req_i   (stall_req_i),
    .stage_valid_i (stage_valid_i),
    .flush_req_i   (flush_req_i),
    .flush_mask_i  (flush_mask_i),
    .flush_ack_o   (flush_ack_o),
    .halt_req_i    (halt_req_i),
    .halt_ack_o    (halt_ack_o),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .busy_o        (busy_o),
    .perf_clear_i  (perf_clear_i),
    .stall_cycles_o(stall_cycles_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string      tag;
    logic [3:0] stall;
    logic [3:0] flush;
    logic       ack;
    logic       hack;
    logic       busy;
    logic [3:0] perf;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   perf_model = 0;

  task automatic chk(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard", "empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, "stall_o", 32'(stall_o), 32'(e.stall));
      chk(e.tag, "flush_o", 32'(flush_o), 32'(e.flush));
      chk(e.tag, "flush_ack_o", 32'(flush_ack_o), 32'(e.ack));
      chk(e.tag, "halt_ack_o", 32'(halt_ack_o), 32'(e.hack));
      chk(e.tag, "busy_o", 32'(busy_o), 32'(e.busy));
      chk(e.tag, "stall_cycles_o", 32'(stall_cycles_o), 32'(e.perf));
    end
  endtask

  // One clock cycle: drive inputs, push expectation, sample mid-cycle, advance.
  task automatic cyc(input string tag, input logic [3:0] sreq, input logic [3:0] vld,
                     input logic freq, input logic [3:0] fmask, input logic hreq,
                     input logic pclr, input logic [3:0] e_stall, input logic [3:0] e_flush,
                     input logic e_ack, input logic e_hack, input logic e_busy);
    exp_t e;
    stall_req_i   = sreq;
    stage_valid_i = vld;
    flush_req_i   = freq;
    flush_mask_i  = fmask;
    halt_req_i    = hreq;
    perf_clear_i  = pclr;
    e.tag   = tag;
    e.stall = e_stall;
    e.flush = e_flush;
    e.ack   = e_ack;
    e.hack  = e_hack;
    e.busy  = e_busy;
    e.perf  = PerfEn ? 4'(perf_model) : 4'h0;
    sb.push_back(e);
    #1;
    check_pop();
    if (pclr) perf_model = 0;
    else if (e_stall[0] && perf_model < 15) perf_model++;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni        = 1'b0;
    stall_req_i   = 4'b0100;
    stage_valid_i = 4'b0000;
    flush_req_i   = 1'b0;
    flush_mask_i  = 4'b0000;
    halt_req_i    = 1'b0;
    perf_clear_i  = 1'b0;
    #3;
    chk("reset", "stall_o", 32'(stall_o), 32'h7);
    chk("reset", "flush_o", 32'(flush_o), 32'h0);
    chk("reset", "flush_ack_o", 32'(flush_ack_o), 32'h0);
    chk("reset", "halt_ack_o", 32'(halt_ack_o), 32'h0);
    chk("reset", "busy_o", 32'(busy_o), 32'h0);
    chk("reset", "stall_cycles_o", 32'(stall_cycles_o), 32'h0);
    stall_req_i = 4'b0000;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Back-pressure in IDLE
    cyc("bp_0100", 4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 4'b0111, 4'b0000, 0, 0, 0);
    cyc("bp_0001", 4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
    cyc("bp_1010", 4'b1010, 4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 0, 0);

    // Masked flush, two cycles long
    cyc("fl_req", 4'b0000, 4'b0000, 1, 4'b0110, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("fl_t1", 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0110, 0, 0, 1);
    cyc("fl_t2", 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0110, 1, 0, 1);
    cyc("fl_idle", 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Zero mask; request held into FLUSH is ignored there
    cyc("m0_req", 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("m0_t1", 4'b0000, 4'b0000, 1, 4'b1111, 0, 0, 4'b1111, 4'b0000, 0, 0, 1);
    cyc("m0_t2", 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000, 1, 0, 1);
    cyc("m0_idle", 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Drain to halt
    cyc("dr_req", 4'b0000, 4'b1010, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("dr_1", 4'b0100, 4'b1010, 0, 4'b0000, 1, 0, 4'b0111, 4'b0000, 0, 0, 1);
    cyc("dr_2", 4'b0000, 4'b1000, 0, 4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 0, 1);
    cyc("dr_3", 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 0, 1);
    cyc("halted", 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 1, 1);

    // Flush while halted returns through DRAIN to HALTED
    cyc("hf_req", 4'b0000, 4'b0000, 1, 4'b1111, 1, 0, 4'b1111, 4'b0000, 0, 1, 1);
    cyc("hf_t1", 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 4'b1111, 4'b1111, 0, 0, 1);
    cyc("hf_t2", 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 4'b1111, 4'b1111, 1, 0, 1);
    cyc("hf_drain", 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 0, 1);
    cyc("hf_halt", 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 1, 1);

    // Release halt
    cyc("un_drop", 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 1, 1);
    cyc("un_idle", 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Asynchronous reset mid-flush (counter = 1)
    cyc("rf_req", 4'b0000, 4'b0000, 1, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    flush_req_i = 1'b0;
    #1;
    chk("rf_pre", "flush_o", 32'(flush_o), 32'hf);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rf_rst", "flush_o", 32'(flush_o), 32'h0);
    chk("rf_rst", "busy_o", 32'(busy_o), 32'h0);
    chk("rf_rst", "stall_cycles_o", 32'(stall_cycles_o), 32'h0);
    @(posedge clk_i);
    #1;
    chk("rf_rst", "flush_ack_o", 32'(flush_ack_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    perf_model = 0;
    @(posedge clk_i);
    #1;
    cyc("rf_after", 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Counter saturation and clear (clear wins over increment)
    for (int i = 0; i < 20; i++) begin
      cyc("sat", 4'b1000, 4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 0, 0);
    end
    cyc("clr", 4'b1000, 4'b0000, 0, 4'b0000, 0, 1, 4'b1111, 4'b0000, 0, 0, 0);
    cyc("post_clr", 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("post_clr2", 4'b0010, 4'b0000, 0, 4'b0000, 0, 0, 4'b0011, 4'b0000, 0, 0, 0);
    cyc("final", 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
